// File: rtl/pixel_histogram.sv
// pixel_histogram: per-frame histogram of a processed pixel stream.
// Bins are cleared in place (one per cycle), accumulated through a two-stage
// read/increment/write pipeline with forwarding, then frozen for random-access
// readout until a clear request re-arms the block.
module pixel_histogram #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] pix_data,
    input  logic               pix_last,
    output logic               pix_ready,
    output logic               frame_done,
    input  logic               clear_req,
    input  logic               rd_en,
    input  logic [PIXEL_W-1:0] rd_addr,
    output logic               rd_valid,
    output logic [COUNT_W-1:0] rd_data,
    output logic [COUNT_W-1:0] pix_total
);

    localparam int unsigned       NBINS    = 1 << PIXEL_W;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [PIXEL_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bin storage: single write port, reads captured into registers.
    logic [COUNT_W-1:0] bin_mem [NBINS];

    state_e             state_q,      state_d;
    logic [PIXEL_W-1:0] clr_idx_q,    clr_idx_d;
    logic               last_q,       last_d;
    logic               s1_vld_q,     s1_vld_d;
    logic [PIXEL_W-1:0] s1_pix_q,     s1_pix_d;
    logic [COUNT_W-1:0] s1_rd_q,      s1_rd_d;
    logic               s2_vld_q,     s2_vld_d;
    logic [PIXEL_W-1:0] s2_pix_q,     s2_pix_d;
    logic [COUNT_W-1:0] s2_cnt_q,     s2_cnt_d;
    logic               pix_ready_q,  pix_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               rd_valid_q,   rd_valid_d;
    logic [COUNT_W-1:0] rd_data_q,    rd_data_d;
    logic [COUNT_W-1:0] pix_total_q,  pix_total_d;

    logic               accept_c;
    logic [COUNT_W-1:0] s1_base_c;
    logic [COUNT_W-1:0] s1_inc_c;
    logic               mem_we_c;
    logic [PIXEL_W-1:0] mem_waddr_c;
    logic [COUNT_W-1:0] mem_wdata_c;

    // Next-state, pipeline and memory write-port control.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        last_d       = last_q;
        s1_vld_d     = 1'b0;
        s1_pix_d     = s1_pix_q;
        s1_rd_d      = s1_rd_q;
        s2_vld_d     = 1'b0;
        s2_pix_d     = s2_pix_q;
        s2_cnt_d     = s2_cnt_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        pix_total_d  = pix_total_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = s1_pix_q;
        mem_wdata_c  = '0;

        accept_c = pix_valid && pix_ready_q;

        // The bin written at the previous edge is not yet visible in s1_rd_q.
        s1_base_c = (s2_vld_q && (s2_pix_q == s1_pix_q)) ? s2_cnt_q : s1_rd_q;
        s1_inc_c  = (s1_base_c == CNT_MAX) ? s1_base_c : s1_base_c + COUNT_W'(1);

        if (accept_c) begin
            s1_vld_d = 1'b1;
            s1_pix_d = pix_data;
            s1_rd_d  = bin_mem[pix_data];
        end

        if (s1_vld_q) begin
            s2_vld_d    = 1'b1;
            s2_pix_d    = s1_pix_q;
            s2_cnt_d    = s1_inc_c;
            mem_we_c    = 1'b1;
            mem_waddr_c = s1_pix_q;
            mem_wdata_c = s1_inc_c;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_idx_q;
                mem_wdata_c = '0;
                clr_idx_d   = clr_idx_q + PIXEL_W'(1);
                if (clr_idx_q == IDX_LAST) begin
                    state_d   = ST_ACCUM;
                    clr_idx_d = '0;
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    if (pix_total_q != CNT_MAX) begin
                        pix_total_d = pix_total_q + COUNT_W'(1);
                    end
                    if (pix_last) begin
                        last_d = 1'b1;
                    end
                end
                // Last pixel sits in S1 now; its write lands on this edge.
                if (last_q) begin
                    state_d = ST_DONE;
                    last_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = bin_mem[rd_addr];
                end
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    clr_idx_d   = '0;
                    pix_total_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
                last_d    = 1'b0;
            end
        endcase

        pix_ready_d  = (state_d == ST_ACCUM) && !last_d;
        frame_done_d = (state_d == ST_DONE);
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            last_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_pix_q     <= '0;
            s1_rd_q      <= '0;
            s2_vld_q     <= 1'b0;
            s2_pix_q     <= '0;
            s2_cnt_q     <= '0;
            pix_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            pix_total_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            last_q       <= last_d;
            s1_vld_q     <= s1_vld_d;
            s1_pix_q     <= s1_pix_d;
            s1_rd_q      <= s1_rd_d;
            s2_vld_q     <= s2_vld_d;
            s2_pix_q     <= s2_pix_d;
            s2_cnt_q     <= s2_cnt_d;
            pix_ready_q  <= pix_ready_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            pix_total_q  <= pix_total_d;
        end
    end

    // Bin array write port; contents are initialised by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            bin_mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign frame_done = frame_done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign pix_total  = pix_total_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// Scoreboard bench for pixel_histogram: a full-width instance and a 4-bit
// counter instance share one stimulus stream; a behavioural bin model
// produces expected read data for both, saturated to each counter width.
module tb_pixel_histogram;

    localparam int PW  = 8;
    localparam int CW  = 20;
    localparam int CWS = 4;
    localparam int NB  = 1 << PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_last;
    logic          clear_req;
    logic          rd_en;
    logic [PW-1:0] rd_addr;

    logic           rdy_a, done_a, rdv_a;
    logic [CW-1:0]  rdd_a, tot_a;
    logic           rdy_b, done_b, rdv_b;
    logic [CWS-1:0] rdd_b, tot_b;

    pixel_histogram #(.PIXEL_W(PW), .COUNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .pix_ready(rdy_a), .frame_done(done_a), .clear_req(clear_req),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rdv_a),
        .rd_data(rdd_a), .pix_total(tot_a)
    );

    pixel_histogram #(.PIXEL_W(PW), .COUNT_W(CWS)) u_sat (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .pix_ready(rdy_b), .frame_done(done_b), .clear_req(clear_req),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rdv_b),
        .rd_data(rdd_b), .pix_total(tot_b)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int mdl_bin [NB];
    int mdl_tot;

    typedef struct {
        int a;
        int b;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) mdl_bin[i] = 0;
        mdl_tot = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!rdy_a && n < 600) begin
            step();
            n++;
        end
        check("ready_wait", 32'(rdy_a), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_a && n < 20) begin
            step();
            n++;
        end
        check("done_wait", 32'(done_a), 1);
        check("done_wait_sat", 32'(done_b), 1);
    endtask

    task automatic put_pix(input int v, input bit last);
        wait_ready();
        pix_valid = 1'b1;
        pix_data  = PW'(v);
        pix_last  = last;
        mdl_bin[v]++;
        mdl_tot++;
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic read_bin(input int a);
        exp_t e;
        e.a = sat(mdl_bin[a], CW);
        e.b = sat(mdl_bin[a], CWS);
        rd_en   = 1'b1;
        rd_addr = PW'(a);
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        check("rd_pending", exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        model_clear();
        check("tot_cleared", 32'(tot_a), 0);
        check("done_cleared", 32'(done_a), 0);
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_tot"}, 32'(tot_a), sat(mdl_tot, CW));
        check({tag, "_tot_sat"}, 32'(tot_b), sat(mdl_tot, CWS));
    endtask

    // Read-response scoreboard: every rd_valid must match a queued expectation.
    always @(negedge clk) begin
        if (rdv_a) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_data", 32'(rdd_a), mon_e.a);
                check("rd_data_sat", 32'(rdd_b), mon_e.b);
                check("rd_valid_sat", 32'(rdv_b), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b0;
        pix_valid = 1'b1;
        pix_data  = '0;
        pix_last  = 1'b0;
        clear_req = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        model_clear();

        // Reset values, then CLEAR sweep length with pix_valid held high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_rdv", 32'(rdv_a), 0);
        check("rst_rdd", 32'(rdd_a), 0);
        check("rst_tot", 32'(tot_a), 0);
        rst = 1'b1;
        n = 0;
        while (!rdy_a && n < 400) begin
            step();
            n++;
        end
        check("clear_len", n, 256);
        check("clear_len_sat", 32'(rdy_b), 1);

        // Single-pixel frame.
        put_pix(8'h37, 1'b1);
        check("t1_ready_drop", 32'(rdy_a), 0);
        check("t1_done_early", 32'(done_a), 0);
        step();
        check("t1_done_t2", 32'(done_a), 1);
        check_totals("t1");
        for (int i = 0; i < NB; i++) read_bin(i);
        drain();

        // Ramp frame 0..15.
        do_clear();
        for (int v = 0; v < 16; v++) put_pix(v, v == 15);
        check("t2_ready_drop", 32'(rdy_a), 0);
        wait_done();
        for (int i = 0; i <= 16; i++) read_bin(i);
        drain();
        check_totals("t2");

        // Long run of one value, then A,idle,A,A.
        do_clear();
        for (int i = 0; i < 200; i++) put_pix(200, 1'b0);
        put_pix(5, 1'b0);
        idle();
        put_pix(5, 1'b0);
        put_pix(5, 1'b1);
        wait_done();
        read_bin(200); read_bin(5); read_bin(199);
        read_bin(201); read_bin(4); read_bin(6);
        drain();
        check_totals("t3");

        // Saturation, then read and clear in the same cycle.
        do_clear();
        for (int i = 0; i < 20; i++) put_pix(7, i == 19);
        wait_done();
        check_totals("t4");
        begin
            exp_t e;
            e.a = sat(mdl_bin[7], CW);
            e.b = sat(mdl_bin[7], CWS);
            exp_q.push_back(e);
        end
        rd_en     = 1'b1;
        rd_addr   = 8'd7;
        clear_req = 1'b1;
        step();
        rd_en     = 1'b0;
        clear_req = 1'b0;
        model_clear();
        check("t4_clear_tot", 32'(tot_a), 0);
        drain();
        put_pix(1, 1'b1);
        wait_done();
        read_bin(7); read_bin(1);
        drain();

        // Read and clear strobes during ACCUM are ignored.
        do_clear();
        for (int i = 0; i < 5; i++) put_pix(3, 1'b0);
        rd_en     = 1'b1;
        rd_addr   = 8'd3;
        clear_req = 1'b1;
        step();
        rd_en     = 1'b0;
        clear_req = 1'b0;
        check("t5_ready", 32'(rdy_a), 1);
        check("t5_done", 32'(done_a), 0);
        step();
        check("t5_rdv", 32'(rdv_a), 0);
        put_pix(3, 1'b0);
        put_pix(3, 1'b1);
        wait_done();
        read_bin(3);
        drain();
        check_totals("t5");

        // Reset in the middle of a frame.
        do_clear();
        for (int i = 0; i < 50; i++) put_pix(9, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(rdy_a), 0);
        check("t6_rst_done", 32'(done_a), 0);
        check("t6_rst_rdv", 32'(rdv_a), 0);
        check("t6_rst_rdd", 32'(rdd_a), 0);
        check("t6_rst_tot", 32'(tot_a), 0);
        check("t6_rst_tot_sat", 32'(tot_b), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (!rdy_a && n < 400) begin
            step();
            n++;
        end
        check("t6_clear_len", n, 256);
        for (int i = 0; i < 4; i++) put_pix(9, i == 3);
        wait_done();
        read_bin(9); read_bin(0);
        drain();
        check_totals("t6");

        repeat (2) step();
        check("end_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
